// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_pkg;

  typedef enum logic [2:0] {
    StBoot,
    StRun,
    StMemWait,
    StHalting,
    StHalted
  } pctl_state_t;

  localparam logic [4:0] XzrReg = 5'd31;

  // Cycles needed to empty ID, EX and MEM before the core is halted.
  localparam int unsigned DrainDepth = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot flush, load-use and
// memory-wait stalls, branch flush and debug halt/resume.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_ab,
  input  logic             id_uses_rn,
  input  logic             id_uses_ab,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             id_brtaken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned BootW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BootW-1:0] BootLast = BootW'(BOOT_CYCLES - 1);
  localparam logic [1:0] DrainLast = 2'(DrainDepth - 1);

  pctl_state_t      state_q, state_d;
  logic [BootW-1:0] boot_cnt_q, boot_cnt_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic             pending_q, pending_d;

  logic load_use;
  logic frozen;
  logic stall_inc;

  // Loads into XZR never produce a value, so they cannot cause a hazard.
  assign load_use = ex_memread && (ex_rd != XzrReg) &&
                    ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_ab && (id_ab == ex_rd)));

  // Once in MEM_WAIT only mem_ready ends the freeze.
  assign frozen = (state_q == StMemWait) ? !mem_ready : (mem_req && !mem_ready);

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_we      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_we     = 1'b1;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    pending_d    = pending_q;

    unique case (state_q)
      StBoot: begin
        pc_we        = 1'b0;
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
        if (boot_cnt_q == BootLast) begin
          boot_cnt_d = '0;
          state_d    = StRun;
        end else begin
          boot_cnt_d = boot_cnt_q + BootW'(1);
        end
      end

      StRun, StMemWait: begin
        pending_d = pending_q || halt_req;
        if (frozen) begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_we     = 1'b0;
          memwb_bubble = 1'b1;
          state_d      = StMemWait;
        end else begin
          state_d = StRun;
          if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_brtaken) begin
            ifid_flush = 1'b1;
          end
          if ((state_q == StRun) && pending_q && !load_use) begin
            state_d = StHalting;
          end
        end
      end

      StHalting: begin
        if (mem_req && !mem_ready) begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_we     = 1'b0;
          memwb_bubble = 1'b1;
        end else begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
          if (drain_cnt_q == DrainLast) begin
            drain_cnt_d = '0;
            state_d     = StHalted;
          end else begin
            drain_cnt_d = drain_cnt_q + 2'd1;
          end
        end
      end

      StHalted: begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_we     = 1'b0;
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
        halted       = 1'b1;
        if (resume) begin
          // A halt request alongside resume re-arms the halt.
          pending_d = halt_req;
          state_d   = StRun;
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StBoot;
      boot_cnt_q  <= '0;
      drain_cnt_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pending_q   <= pending_d;
    end
  end

  assign stall_inc = ((state_q == StRun) || (state_q == StMemWait)) && !pc_we;

  sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (stall_inc),
    .count(stall_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int unsigned BootCycles = 4;
  localparam int unsigned CntW       = 4;
  localparam int unsigned CntMax     = (1 << CntW) - 1;

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble, halted}
  localparam logic [7:0] CtlBoot    = 8'b0111_1110;
  localparam logic [7:0] CtlRun     = 8'b1101_0100;
  localparam logic [7:0] CtlFreeze  = 8'b0000_0010;
  localparam logic [7:0] CtlLoadUse = 8'b0001_1100;
  localparam logic [7:0] CtlBranch  = 8'b1111_0100;
  localparam logic [7:0] CtlDrain   = 8'b0111_0100;
  localparam logic [7:0] CtlHalted  = 8'b0000_1011;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      id_rn, id_ab, ex_rd;
  logic            id_uses_rn, id_uses_ab, ex_memread, id_brtaken;
  logic            mem_req, mem_ready, halt_req, resume;
  logic            pc_we, ifid_we, ifid_flush, idex_we, idex_bubble;
  logic            exmem_we, memwb_bubble, halted;
  logic [CntW-1:0] stall_count;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .BOOT_CYCLES(BootCycles),
    .CNT_W      (CntW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rn       (id_rn),
    .id_ab       (id_ab),
    .id_uses_rn  (id_uses_rn),
    .id_uses_ab  (id_uses_ab),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .id_brtaken  (id_brtaken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .halt_req    (halt_req),
    .resume      (resume),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_we     (idex_we),
    .idex_bubble (idex_bubble),
    .exmem_we    (exmem_we),
    .memwb_bubble(memwb_bubble),
    .halted      (halted),
    .stall_count (stall_count)
  );

  logic [7:0] obs_ctl;
  assign obs_ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble,
                    halted};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining boot cycles, busy/drain/halt flags, stall tally.
  int          boot_left, drain_left;
  bit          mem_busy, draining, halted_m, pending;
  int unsigned cnt;
  int          nx_boot_left, nx_drain_left;
  bit          nx_mem_busy, nx_draining, nx_halted, nx_pending;
  int unsigned nx_cnt;
  logic [7:0]  e_ctl;

  task automatic model_reset();
    boot_left = BootCycles; drain_left = 0;
    mem_busy = 0; draining = 0; halted_m = 0; pending = 0; cnt = 0;
  endtask

  task automatic model_eval();
    bit lu, wt;
    lu = ex_memread && (ex_rd != 5'd31) &&
         ((id_uses_rn && id_rn == ex_rd) || (id_uses_ab && id_ab == ex_rd));
    nx_boot_left = boot_left; nx_drain_left = drain_left; nx_mem_busy = mem_busy;
    nx_draining = draining; nx_halted = halted_m; nx_pending = pending; nx_cnt = cnt;
    if (boot_left > 0) begin
      e_ctl = CtlBoot;
      nx_boot_left = boot_left - 1;
    end else if (halted_m) begin
      e_ctl = CtlHalted;
      if (resume) begin
        nx_halted  = 0;
        nx_pending = halt_req;
      end
    end else if (draining) begin
      if (mem_req && !mem_ready) e_ctl = CtlFreeze;
      else begin
        e_ctl = CtlDrain;
        nx_drain_left = drain_left - 1;
        if (drain_left == 1) begin
          nx_draining = 0;
          nx_halted   = 1;
        end
      end
    end else begin
      nx_pending = pending || halt_req;
      wt = mem_busy ? !mem_ready : (mem_req && !mem_ready);
      if (wt) begin
        e_ctl = CtlFreeze;
        nx_mem_busy = 1;
      end else begin
        nx_mem_busy = 0;
        if (lu) e_ctl = CtlLoadUse;
        else if (id_brtaken) e_ctl = CtlBranch;
        else e_ctl = CtlRun;
        if (!mem_busy && pending && !lu) begin
          nx_draining   = 1;
          nx_drain_left = 3;
        end
      end
      if (!e_ctl[7] && nx_cnt < CntMax) nx_cnt++;
    end
  endtask

  task automatic model_commit();
    boot_left = nx_boot_left; drain_left = nx_drain_left; mem_busy = nx_mem_busy;
    draining = nx_draining; halted_m = nx_halted; pending = nx_pending; cnt = nx_cnt;
  endtask

  // Entered just after a falling edge with inputs applied; leaves at the next falling edge.
  task automatic run_cycle(input string tag);
    #1;
    model_eval();
    check_eq({tag, ":ctl"}, 32'(obs_ctl), 32'(e_ctl));
    check_eq({tag, ":cnt"}, 32'(stall_count), cnt);
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rn = 5'd0; id_ab = 5'd0; ex_rd = 5'd0;
    id_uses_rn = 0; id_uses_ab = 0; ex_memread = 0; id_brtaken = 0;
    mem_req = 0; mem_ready = 0; halt_req = 0; resume = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("reset:ctl", 32'(obs_ctl), 32'(CtlBoot));
    check_eq("reset:cnt", 32'(stall_count), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [4:0] pick_reg();
    int unsigned r;
    r = $urandom_range(0, 3);
    return (r == 3) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    reset = 1'b0;
    idle_inputs();
    do_reset();

    // Boot: four flushed cycles, then the first fetching cycle.
    for (int i = 0; i < BootCycles; i++) run_cycle("boot");
    #1;
    check_eq("boot_done:pc_we", 32'(pc_we), 1);
    run_cycle("run0");

    // Load-use on Rn, then the same pattern through XZR.
    ex_memread = 1; ex_rd = 5'd1; id_uses_rn = 1; id_rn = 5'd1;
    run_cycle("ldu");
    idle_inputs();
    check_eq("ldu:count", 32'(stall_count), 1);
    ex_memread = 1; ex_rd = 5'd31; id_uses_rn = 1; id_rn = 5'd31;
    run_cycle("ldu_xzr");
    idle_inputs();

    // Load-use beats branch; the branch flushes on the next cycle.
    ex_memread = 1; ex_rd = 5'd2; id_uses_ab = 1; id_ab = 5'd2; id_brtaken = 1;
    run_cycle("ldu_br");
    ex_memread = 0;
    run_cycle("br_after");
    idle_inputs();

    // Three-cycle memory wait.
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) run_cycle("memwait");
    mem_ready = 1;
    run_cycle("memdone");
    idle_inputs();
    check_eq("memwait:count", 32'(stall_count), 5);

    // Halt requested during a memory wait, drain, halt, resume.
    mem_req = 1; mem_ready = 0;
    run_cycle("hmw0");
    halt_req = 1;
    run_cycle("hmw1");
    halt_req = 0; mem_ready = 1;
    run_cycle("hmw_done");
    idle_inputs();
    for (int i = 0; i < 5; i++) run_cycle("drain");
    #1;
    check_eq("halted", 32'(halted), 1);
    run_cycle("halted_idle");
    resume = 1;
    run_cycle("resume");
    idle_inputs();
    #1;
    check_eq("resume:pc_we", 32'(pc_we), 1);
    run_cycle("after_resume");

    // Long memory wait saturates the stall counter.
    do_reset();
    for (int i = 0; i < BootCycles; i++) run_cycle("boot2");
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 20; i++) run_cycle("sat");
    check_eq("sat:count", 32'(stall_count), CntMax);
    mem_ready = 1;
    run_cycle("sat_done");
    idle_inputs();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      id_rn      = pick_reg();
      id_ab      = pick_reg();
      ex_rd      = pick_reg();
      id_uses_rn = 1'($urandom_range(0, 1));
      id_uses_ab = 1'($urandom_range(0, 1));
      ex_memread = ($urandom_range(0, 2) == 0);
      id_brtaken = ($urandom_range(0, 3) == 0);
      mem_req    = ($urandom_range(0, 3) == 0);
      mem_ready  = 1'($urandom_range(0, 1));
      halt_req   = ($urandom_range(0, 24) == 0);
      resume     = ($urandom_range(0, 3) == 0);
      run_cycle("rand");
    end
    idle_inputs();

    // Reset asserted while draining toward HALTED.
    do_reset();
    for (int i = 0; i < BootCycles; i++) run_cycle("boot3");
    ex_memread = 1; ex_rd = 5'd3; id_uses_rn = 1; id_rn = 5'd3;
    run_cycle("pre_halt_ldu");
    idle_inputs();
    halt_req = 1;
    run_cycle("halt_req");
    halt_req = 0;
    for (int i = 0; i < 10 && !draining; i++) run_cycle("to_drain");
    check_eq("drain_reached", 32'(draining), 1);
    run_cycle("drain_mid");
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_halt_rst:ctl", 32'(obs_ctl), 32'(CtlBoot));
    check_eq("mid_halt_rst:cnt", 32'(stall_count), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < BootCycles + 2; i++) run_cycle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
